// File: rtl/minmax_pkg.sv
// minmax_pkg -- shared definitions for the min/max window tracker.
//   MODE_RUNNING / MODE_WINDOW : encodings of the minmax_window mode input.
//   is_greater / is_less       : magnitude compare of two zero-extended
//                                w-bit values. sgn=1 gives a two's-complement
//                                compare and sgn=0 an unsigned one. Operands
//                                may be up to CMP_MAXW bits wide.
package minmax_pkg;

    localparam logic MODE_RUNNING = 1'b0;
    localparam logic MODE_WINDOW  = 1'b1;

    localparam int CMP_MAXW = 64;

    // Flipping the sign bit maps two's-complement order onto unsigned
    // order. The caller's value is zero-extended, so bits above w-1 are
    // zero in both operands.
    function automatic logic [CMP_MAXW-1:0] cmp_key(input logic [CMP_MAXW-1:0] v,
                                                    input int w, input logic sgn);
        return v ^ (CMP_MAXW'(sgn) << (w - 1));
    endfunction

    function automatic logic is_greater(input logic [CMP_MAXW-1:0] a,
                                        input logic [CMP_MAXW-1:0] b,
                                        input int w, input logic sgn);
        return cmp_key(a, w, sgn) > cmp_key(b, w, sgn);
    endfunction

    function automatic logic is_less(input logic [CMP_MAXW-1:0] a,
                                     input logic [CMP_MAXW-1:0] b,
                                     input int w, input logic sgn);
        return cmp_key(a, w, sgn) < cmp_key(b, w, sgn);
    endfunction

endpackage

// File: rtl/minmax_reduce.sv
// minmax_reduce -- combinational min/max over the masked entries of a buffer.
//   entries : DEPTH samples, WIDTH bits each
//   valid   : one bit per entry; only set entries take part
//   max/min : extremes of the valid entries, 0 when no entry is valid
// On ties the lower-index entry is kept. Ties cannot change the value.
module minmax_reduce
    import minmax_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] entries,
    input  logic [DEPTH-1:0]            valid,
    output logic [WIDTH-1:0]            max,
    output logic [WIDTH-1:0]            min
);

    logic found;

    always_comb begin
        found = 1'b0;
        max   = '0;
        min   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                if (!found) begin
                    max   = entries[i];
                    min   = entries[i];
                    found = 1'b1;
                end else begin
                    if (is_greater(CMP_MAXW'(entries[i]), CMP_MAXW'(max), WIDTH, SIGNED != 0))
                        max = entries[i];
                    if (is_less(CMP_MAXW'(entries[i]), CMP_MAXW'(min), WIDTH, SIGNED != 0))
                        min = entries[i];
                end
            end
        end
    end

endmodule

// File: rtl/minmax_window.sv
// minmax_window -- running and sliding-window min/max tracker.
//   clock, reset     : rising-edge clock and synchronous active-high reset
//   in_valid, data   : sample input, accepted when in_valid=1 and reset=0
//   mode             : 0 gives running (all-time) extremes, 1 gives the
//                      extremes of the last DEPTH samples
//   out_valid        : at least one sample has been held since reset
//   max, min         : selected extremes, registered (latency 1)
//   count            : window occupancy, saturates at DEPTH
//   range            : max-min (WIDTH+1 bits, unsigned). Present only when
//                      MINMAX_WINDOW_RANGE_EN is defined.
// WIDTH must be 2..64. DEPTH must be a power of two and at least 2.
module minmax_window
    import minmax_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       data,
    input  logic                   mode,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       max,
    output logic [WIDTH-1:0]       min,
    output logic [$clog2(DEPTH):0] count
`ifdef MINMAX_WINDOW_RANGE_EN
    ,
    output logic [WIDTH:0]         range
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] buf_q, buf_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        valid_q, valid_d;
    logic [WIDTH-1:0]            run_max_q, run_max_d, run_min_q, run_min_d;
    logic [WIDTH-1:0]            max_q, max_d, min_q, min_d;
    logic [DEPTH-1:0]            occ_d;
    logic [WIDTH-1:0]            win_max, win_min;

    // Next stored state. Reset priority is applied in the flop block.
    always_comb begin
        buf_d     = buf_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        valid_d   = valid_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        if (in_valid) begin
            buf_d[wr_ptr_q] = data;
            wr_ptr_d        = wr_ptr_q + PW'(1);  // wraps at DEPTH (power of two)
            if (count_q != CW'(DEPTH))
                count_d = count_q + CW'(1);
            valid_d = 1'b1;
            if (!valid_q) begin
                run_max_d = data;
                run_min_d = data;
            end else begin
                if (is_greater(CMP_MAXW'(data), CMP_MAXW'(run_max_q), WIDTH, SIGNED != 0))
                    run_max_d = data;
                if (is_less(CMP_MAXW'(data), CMP_MAXW'(run_min_q), WIDTH, SIGNED != 0))
                    run_min_d = data;
            end
        end
    end

    // Entries fill from index 0 after reset. The occupied set is therefore
    // always the first count_d slots.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++)
            occ_d[i] = CW'(i) < count_d;
    end

    // The reduction sees next-state contents, so a sample accepted this edge
    // is included in the registered windowed result.
    minmax_reduce #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .SIGNED (SIGNED)
    ) u_reduce (
        .entries (buf_d),
        .valid   (occ_d),
        .max     (win_max),
        .min     (win_min)
    );

    always_comb begin
        max_d = '0;
        min_d = '0;
        if (valid_d) begin
            max_d = (mode == MODE_WINDOW) ? win_max : run_max_d;
            min_d = (mode == MODE_WINDOW) ? win_min : run_min_d;
        end
    end

`ifdef MINMAX_WINDOW_RANGE_EN
    logic [WIDTH:0] range_q, range_d;

    // Extend by one bit. The true difference lies in 0..2^WIDTH-1, so it fits.
    always_comb begin
        range_d = {(SIGNED != 0) & max_d[WIDTH-1], max_d}
                - {(SIGNED != 0) & min_d[WIDTH-1], min_d};
    end

    always_ff @(posedge clock) begin
        if (reset) range_q <= '0;
        else       range_q <= range_d;
    end

    assign range = range_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            run_max_q <= '0;
            run_min_q <= '0;
            max_q     <= '0;
            min_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            max_q     <= max_d;
            min_q     <= min_d;
        end
    end

    // Buffer data needs no reset. Entries count only when the occupancy
    // covers them, so clearing count invalidates every entry.
    always_ff @(posedge clock) begin
        if (!reset) buf_q <= buf_d;
    end

    assign out_valid = valid_q;
    assign max       = max_q;
    assign min       = min_q;
    assign count     = count_q;

endmodule
